// File: rtl/contador_programa_if.sv
// rtl/contador_programa_if.sv - fetch-side bus between the program counter and its pipeline/imem neighbours
interface contador_programa_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_addr;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] pc_out;
  logic             imem_req;
  logic             imem_ready;
  logic             fetch_valid;
  logic             misalign;

  // master: the program counter itself; slave: pipeline, adder and instruction memory
  modport master (
    input  stall, redirect_valid, redirect_addr, pc_plus4, imem_ready,
    output pc_out, imem_req, fetch_valid, misalign
  );

  modport slave (
    output stall, redirect_valid, redirect_addr, pc_plus4, imem_ready,
    input  pc_out, imem_req, fetch_valid, misalign
  );
endinterface

// File: rtl/contador_programa.sv
// rtl/contador_programa.sv - fetch program counter with BOOT/REQ/HALT sequencing; FETCH_COUNT_EN adds fetch_count
module contador_programa #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  contador_programa_if.master  bus
`ifdef FETCH_COUNT_EN
  ,
  output logic [WIDTH-1:0]     fetch_count
`endif
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] pc;
  logic             misalign_q;
  logic             req;
  logic             accepted;

  // Request is withdrawn the same cycle a stall or redirect shows up, so nothing is fetched from a stale PC
  assign req      = (state == REQ) && !bus.stall && !bus.redirect_valid;
  assign accepted = req && bus.imem_ready;

  assign bus.pc_out      = pc;
  assign bus.imem_req    = req;
  assign bus.fetch_valid = accepted;
  assign bus.misalign    = misalign_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= BOOT;
      pc         <= RESET_ADDR;
      misalign_q <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= REQ;
        REQ: begin
          if (bus.redirect_valid) begin
            if (bus.redirect_addr[1:0] == 2'b00) begin
              pc <= bus.redirect_addr;
            end else begin
              misalign_q <= 1'b1;
              state      <= HALT;
            end
          end else if (!bus.stall && accepted) begin
            pc <= bus.pc_plus4;
          end
        end
        HALT: state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  // fetch_valid is never raised in HALT, which is what freezes the count there
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_count <= '0;
    end else if (accepted) begin
      fetch_count <= fetch_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_contador_programa.sv
// tb/tb_contador_programa.sv - directed bench for contador_programa; covers FETCH_COUNT_EN when defined
module tb_contador_programa;
  logic CLK = 1'b0;
  logic RST;
  logic        ovr_en;
  logic [31:0] ovr_val;
  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  contador_programa_if #(.WIDTH(32)) bus ();

  assign bus.pc_plus4 = ovr_en ? ovr_val : bus.pc_out + 32'd4;

`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  contador_programa #(.WIDTH(32), .RESET_ADDR(32'h0)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic req,
                         input logic fv, input logic mis);
    chk({tag, ".pc"}, bus.pc_out, pc);
    chk({tag, ".req"}, {31'd0, bus.imem_req}, {31'd0, req});
    chk({tag, ".fv"}, {31'd0, bus.fetch_valid}, {31'd0, fv});
    chk({tag, ".mis"}, {31'd0, bus.misalign}, {31'd0, mis});
  endtask

  initial begin
    RST = 1'b1;
    ovr_en = 1'b0;
    ovr_val = 32'h0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr = 32'h0;
    bus.imem_ready = 1'b1;

    // reset edge, then BOOT dead cycle
    tick();
    RST = 1'b0;
    #1;
    chk_out("boot", 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("seq0", 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("seq4", 32'h4, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("seq8", 32'h8, 1'b1, 1'b1, 1'b0);

    // memory not ready for three cycles at 0x8
    bus.imem_ready = 1'b0;
    #1;
    chk_out("wait0", 32'h8, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 3; i++) begin
      tick();
      chk_out("waitn", 32'h8, 1'b1, 1'b0, 1'b0);
    end
    tick();
    bus.imem_ready = 1'b1;
    #1;
    chk_out("accept8", 32'h8, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("seqC", 32'hC, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("seq10", 32'h10, 1'b1, 1'b1, 1'b0);

    // redirect wins over a simultaneous stall
    bus.stall = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 32'h100;
    #1;
    chk_out("redir_cyc", 32'h10, 1'b0, 1'b0, 1'b0);
    tick();
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    chk_out("redir100", 32'h100, 1'b1, 1'b1, 1'b0);

    // plain stall holds pc
    bus.stall = 1'b1;
    #1;
    chk_out("stall_cyc", 32'h100, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("stall_hold", 32'h100, 1'b0, 1'b0, 1'b0);
    bus.stall = 1'b0;
    tick();
    chk_out("after_stall", 32'h104, 1'b1, 1'b1, 1'b0);

    // next pc must come from the external adder, not from an internal +4
    ovr_en = 1'b1;
    ovr_val = 32'h40;
    tick();
    ovr_en = 1'b0;
    #1;
    chk_out("plus4_src", 32'h40, 1'b1, 1'b1, 1'b0);

    // address wrap at the top of the space
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk_out("top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("wrap", 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("wrap4", 32'h4, 1'b1, 1'b1, 1'b0);

    // misaligned redirect -> HALT
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 32'h102;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk_out("halt0", 32'h4, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("halt_n", 32'h4, 1'b0, 1'b0, 1'b1);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 32'h200;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk_out("halt_redir", 32'h4, 1'b0, 1'b0, 1'b1);

    // only reset leaves HALT; redirect during BOOT ignored
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 32'h200;
    #1;
    chk_out("rst_boot", 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk_out("boot_redir", 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("post_boot4", 32'h4, 1'b1, 1'b1, 1'b0);

    // reset while a request is pending
    bus.imem_ready = 1'b0;
    #1;
    chk_out("pend", 32'h4, 1'b1, 1'b0, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bus.imem_ready = 1'b1;
    #1;
    chk_out("rst_mid", 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("rst_mid_req", 32'h0, 1'b1, 1'b1, 1'b0);

`ifdef FETCH_COUNT_EN
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("cnt_rst", fetch_count, 32'd0);
    tick();
    for (int i = 0; i < 7; i++) begin
      bus.stall = (i == 2 || i == 4);
      tick();
    end
    bus.stall = 1'b1;
    #1;
    chk("cnt5", fetch_count, 32'd5);
    chk("cnt5_pc", bus.pc_out, 32'h14);
    tick();
    chk("cnt_stall", fetch_count, 32'd5);
    bus.stall = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("cnt_clr", fetch_count, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
